// File: rtl/fsm_test_sim.sv
// Auto-load sequencer for the DCFEB parameter PROM: issues load-address,
// read-array command and read-N to the BPI engine, then waits for done or timeout.
module fsm_test_sim #(
  parameter logic [22:0] AL_BASE_ADDR = 23'h7E0000,
  parameter logic [5:0]  AL_NWORDS    = 6'd36,
  parameter logic [15:0] RD_ARRAY_CMD = 16'h00FF,
  parameter logic [15:0] TIMEOUT      = 16'd1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AL_START,
  input  logic        AL_DONE,
  output logic [22:0] AL_ADDR,
  output logic [15:0] AL_CMD_DATA_OUT,
  output logic [1:0]  AL_OP,
  output logic        AL_EXECUTE,
  output logic        AUTO_LOAD_ENA,
  output logic        CLR_AL_DONE,
  output logic [5:0]  AL_CNT,
  output logic [2:0]  AL_STATUS
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LDA, S_G1, S_CMD, S_G2, S_RDN, S_WAIT, S_FIN
  } state_t;

  state_t      state_reg, state_next;
  logic        start_q;
  logic [15:0] timer_reg;
  logic [2:0]  status_reg, status_next;
  logic        trigger;
  logic        timed_out;

  assign trigger   = AL_START & ~start_q;
  assign timed_out = (timer_reg == (TIMEOUT - 16'd1));
  assign AL_STATUS = status_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= S_IDLE;
      start_q    <= 1'b0;
      timer_reg  <= 16'd0;
      status_reg <= 3'b000;
    end else begin
      state_reg  <= state_next;
      start_q    <= AL_START;
      status_reg <= status_next;
      // Timer restarts as RDN hands over to WAIT, so WAIT's first cycle sees 0.
      if (state_reg == S_RDN)
        timer_reg <= 16'd0;
      else if (state_reg == S_WAIT)
        timer_reg <= timer_reg + 16'd1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    status_next     = status_reg;
    AL_ADDR         = 23'd0;
    AL_CMD_DATA_OUT = 16'd0;
    AL_OP           = 2'b00;
    AL_EXECUTE      = 1'b0;
    AUTO_LOAD_ENA   = 1'b0;
    CLR_AL_DONE     = 1'b0;
    AL_CNT          = 6'd0;
    case (state_reg)
      S_IDLE: begin
        if (trigger) begin
          state_next  = S_CLR;
          status_next = 3'b001;
        end
      end
      S_CLR: begin
        CLR_AL_DONE   = 1'b1;
        AUTO_LOAD_ENA = 1'b1;
        state_next    = S_LDA;
      end
      S_LDA: begin
        AUTO_LOAD_ENA = 1'b1;
        AL_OP         = 2'b01;
        AL_ADDR       = AL_BASE_ADDR;
        AL_EXECUTE    = 1'b1;
        state_next    = S_G1;
      end
      S_G1: begin
        AUTO_LOAD_ENA = 1'b1;
        state_next    = S_CMD;
      end
      S_CMD: begin
        AUTO_LOAD_ENA   = 1'b1;
        AL_OP           = 2'b10;
        AL_CMD_DATA_OUT = RD_ARRAY_CMD;
        AL_EXECUTE      = 1'b1;
        state_next      = S_G2;
      end
      S_G2: begin
        AUTO_LOAD_ENA = 1'b1;
        state_next    = S_RDN;
      end
      S_RDN: begin
        AUTO_LOAD_ENA = 1'b1;
        AL_OP         = 2'b11;
        AL_CNT        = AL_NWORDS - 6'd1;
        AL_EXECUTE    = 1'b1;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        AUTO_LOAD_ENA = 1'b1;
        // Done is checked first so it wins over a coincident timeout.
        if (AL_DONE) begin
          state_next  = S_FIN;
          status_next = 3'b010;
        end else if (timed_out) begin
          state_next  = S_FIN;
          status_next = 3'b100;
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_test_sim.sv
// Randomized bench for fsm_test_sim: expected outputs come from a timeline
// model indexed by cycles since the start edge.
module tb_fsm_test_sim;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        AL_START = 1'b0;
  logic        AL_DONE = 1'b0;
  logic [22:0] AL_ADDR;
  logic [15:0] AL_CMD_DATA_OUT;
  logic [1:0]  AL_OP;
  logic        AL_EXECUTE;
  logic        AUTO_LOAD_ENA;
  logic        CLR_AL_DONE;
  logic [5:0]  AL_CNT;
  logic [2:0]  AL_STATUS;

  int n_checks = 0;
  int n_fail   = 0;

  fsm_test_sim dut (
    .CLK(CLK), .RST(RST), .AL_START(AL_START), .AL_DONE(AL_DONE),
    .AL_ADDR(AL_ADDR), .AL_CMD_DATA_OUT(AL_CMD_DATA_OUT), .AL_OP(AL_OP),
    .AL_EXECUTE(AL_EXECUTE), .AUTO_LOAD_ENA(AUTO_LOAD_ENA),
    .CLR_AL_DONE(CLR_AL_DONE), .AL_CNT(AL_CNT), .AL_STATUS(AL_STATUS)
  );

  always #12 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {ena, clr, exec, op, addr, data, cnt}
  function automatic logic [63:0] obs_vec();
    return {14'd0, AUTO_LOAD_ENA, CLR_AL_DONE, AL_EXECUTE, AL_OP,
            AL_ADDR, AL_CMD_DATA_OUT, AL_CNT};
  endfunction

  function automatic logic [63:0] mk(input bit ena, input bit clr, input bit ex,
                                     input logic [1:0] op, input logic [22:0] a,
                                     input logic [15:0] dat, input logic [5:0] c);
    return {14'd0, ena, clr, ex, op, a, dat, c};
  endfunction

  // Expected bus outputs k cycles after the start edge; FIN is at fin_k.
  function automatic logic [63:0] exp_vec(input int k, input int fin_k);
    if (k == 1) return mk(1, 1, 0, 2'b00, 23'd0, 16'd0, 6'd0);
    if (k == 2) return mk(1, 0, 1, 2'b01, 23'h7E0000, 16'd0, 6'd0);
    if (k == 4) return mk(1, 0, 1, 2'b10, 23'd0, 16'h00FF, 6'd0);
    if (k == 6) return mk(1, 0, 1, 2'b11, 23'd0, 16'd0, 6'd35);
    if (k >= 3 && k < fin_k) return mk(1, 0, 0, 2'b00, 23'd0, 16'd0, 6'd0);
    return 64'd0;
  endfunction

  // One full run: done raised at WAIT cycle d (d > 1023 means never),
  // start held for 'hold' cycles, stale done before WAIT, optional start pulse in WAIT.
  task automatic run_seq(input int d, input int hold, input bit stale, input bit glitch);
    int wait_len;
    int fin_k;
    int g;
    logic [2:0] fin_status;
    wait_len   = (d <= 1023) ? d + 1 : 1024;
    fin_k      = 7 + wait_len;
    fin_status = (d <= 1023) ? 3'b010 : 3'b100;
    g = -100;
    if (glitch && wait_len > 6) g = $urandom_range(wait_len - 4, 0);
    @(negedge CLK);
    AL_START = 1'b1;
    AL_DONE  = stale;
    for (int k = 1; k <= fin_k + 2; k++) begin
      @(negedge CLK);
      check("outs", obs_vec(), exp_vec(k, fin_k));
      if (k >= 2 && k < fin_k) check("busy", {61'd0, AL_STATUS}, 64'd1);
      if (k >= fin_k)          check("fin_status", {61'd0, AL_STATUS}, {61'd0, fin_status});
      AL_START = (k < hold) || (k == 7 + g);
      if (k < 7)
        AL_DONE = stale;
      else if (d <= 1023 && k >= 7 + d)
        AL_DONE = 1'b1;
      else
        AL_DONE = 1'b0;
    end
    $display("run: done_at=%0d hold=%0d stale=%0b glitch=%0b wait_cycles=%0d status=%03b",
             d, hold, stale, glitch, wait_len, AL_STATUS);
  endtask

  initial begin
    // Reset with start held high: nothing may move.
    RST = 1'b0;
    AL_START = 1'b1;
    AL_DONE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("rst_outs", obs_vec(), 64'd0);
      check("rst_status", {61'd0, AL_STATUS}, 64'd0);
    end
    AL_START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("idle_outs", obs_vec(), 64'd0);
    end
    $display("reset: outputs idle, status=%03b", AL_STATUS);

    run_seq(416, 5, 1'b0, 1'b0);   // done after 416 WAIT cycles
    run_seq(2000, 2, 1'b1, 1'b1);  // timeout, stale done, start pulse in WAIT
    run_seq(1023, 1, 1'b1, 1'b0);  // done coincides with timeout
    run_seq(1022, 3, 1'b0, 1'b0);  // done one cycle before timeout
    run_seq(0, 4, 1'b0, 1'b0);     // done on first WAIT cycle

    // Abort during the CMD strobe.
    @(negedge CLK);
    AL_START = 1'b1;
    AL_DONE  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      check("abort_pre", obs_vec(), exp_vec(k, 100));
      AL_START = 1'b0;
    end
    #2 RST = 1'b0;
    #1;
    check("abort_outs", obs_vec(), 64'd0);
    check("abort_status", {61'd0, AL_STATUS}, 64'd0);
    @(negedge CLK);
    check("abort_hold", obs_vec(), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_idle", obs_vec(), 64'd0);
    $display("abort: reset during CMD strobe, outputs=%0h", obs_vec());

    run_seq(37, 2, 1'b0, 1'b1);    // clean sequence after abort

    for (int r = 0; r < 4; r++)
      run_seq(int'($urandom_range(300, 0)), int'($urandom_range(5, 1)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
